// File: rtl/dfd_trace_arbiter.sv
// Purpose: per-source trace capture slots feeding a round-robin arbiter and a one-word output stage.
// Latency: 2 cycles minimum from trigger to trace_out_valid (capture edge, then grant/load edge).
// Backpressure: output word held while trace_out_ready=0; triggers on occupied slots are dropped and counted.
//
// Ports:
//   clk, reset (async, active-low)        - clock and reset
//   trace_en, trigger_in, trace_in         - capture enable, per-source triggers, per-source words
//   trace_out_valid/ready/data/src/ts      - output handshake, granted word, source index, timestamp
//   drop_cnt, overflow                     - saturating lost-capture count, sticky first-drop flag
// Optional feature: define DFD_TRACE_TIMESTAMP_EN to add the 16-bit capture timestamp; otherwise
// trace_out_ts is tied to 0.
module dfd_trace_arbiter #(
    parameter int N      = 4,
    parameter int TRACEw = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 trace_en,
    input  logic [N-1:0]                         trigger_in,
    input  logic [N*TRACEw-1:0]                  trace_in,
    output logic                                 trace_out_valid,
    input  logic                                 trace_out_ready,
    output logic [TRACEw-1:0]                    trace_out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] trace_out_src,
    output logic [15:0]                          trace_out_ts,
    output logic [7:0]                           drop_cnt,
    output logic                                 overflow
);
    localparam int Sw = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_pend;
    logic [TRACEw-1:0] r_word [N];
    logic [Sw-1:0]     r_last;
    logic [TRACEw-1:0] r_out_data;
    logic [Sw-1:0]     r_out_src;
    logic [7:0]        r_drop_cnt;
    logic              r_overflow;

    logic              w_gnt_vld;
    logic [Sw-1:0]     w_gnt_idx;
    logic [N-1:0]      w_gnt_oh;
    logic              w_load;
    logic [N-1:0]      w_take;
    logic [N-1:0]      w_cap;
    logic [N-1:0]      w_drop;
    logic [4:0]        w_drop_n;
    logic [8:0]        w_drop_sum;

    // Round-robin pick: scan from lowest to highest priority so the
    // highest-priority pending slot (last_grant+1) is the final assignment.
    always_comb begin : p_rr
        int          v_idx;
        logic [Sw-1:0] v_sel;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        v_idx     = 0;
        v_sel     = '0;
        for (int k = N; k >= 1; k--) begin
            v_idx = (int'(r_last) + k) % N;
            v_sel = v_idx[Sw-1:0];
            if (r_pend[v_sel]) begin
                w_gnt_vld       = 1'b1;
                w_gnt_idx       = v_sel;
                w_gnt_oh        = '0;
                w_gnt_oh[v_sel] = 1'b1;
            end
        end
    end

    // Output stage: a grant is only taken when the stage is empty or its
    // current word is being accepted this cycle.
    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_gnt_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (trace_out_ready) begin
                    if (w_gnt_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // A slot being granted this cycle counts as free, so a same-cycle
    // trigger on it is captured rather than dropped.
    assign w_take = w_load ? w_gnt_oh : '0;
    assign w_cap  = trigger_in & {N{trace_en}} & (~r_pend | w_take);
    assign w_drop = trigger_in & {N{trace_en}} & r_pend & ~w_take;

    always_comb begin : p_drop_n
        w_drop_n = '0;
        for (int i = 0; i < N; i++) begin
            w_drop_n = w_drop_n + {4'd0, w_drop[i]};
        end
    end

    // Max is 255 + 16, so bit 8 alone flags saturation.
    assign w_drop_sum = {1'b0, r_drop_cnt} + {4'd0, w_drop_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            for (int i = 0; i < N; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_cap[i]) begin
                    r_pend[i] <= 1'b1;
                    r_word[i] <= trace_in[i*TRACEw +: TRACEw];
                end else if (w_take[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_last     <= Sw'(N - 1);
            r_out_data <= '0;
            r_out_src  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_last     <= w_gnt_idx;
                r_out_data <= r_word[w_gnt_idx];
                r_out_src  <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_overflow <= 1'b1;
        end
    end

`ifdef DFD_TRACE_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_ts [N];
    logic [15:0] r_out_ts;

    // Slots latch the counter value seen at their capture edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts_cnt <= '0;
            r_out_ts <= '0;
            for (int i = 0; i < N; i++) begin
                r_ts[i] <= '0;
            end
        end else begin
            r_ts_cnt <= r_ts_cnt + 16'd1;
            for (int i = 0; i < N; i++) begin
                if (w_cap[i]) begin
                    r_ts[i] <= r_ts_cnt;
                end
            end
            if (w_load) begin
                r_out_ts <= r_ts[w_gnt_idx];
            end
        end
    end

    assign trace_out_ts = r_out_ts;
`else
    assign trace_out_ts = 16'd0;
`endif

    assign trace_out_valid = (r_state == S_FULL);
    assign trace_out_data  = r_out_data;
    assign trace_out_src   = r_out_src;
    assign drop_cnt        = r_drop_cnt;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_dfd_trace_arbiter.sv
// Purpose: self-checking bench for dfd_trace_arbiter (vector table plus hand-written corner sequences).
// Latency: expects first valid 2 edges after a trigger edge; words scored in order via a queue.
// Backpressure: toggles trace_out_ready to exercise hold, drop counting and drain behaviour.
module tb_dfd_trace_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           trace_en;
    logic [N-1:0]   trigger_in;
    logic [N*W-1:0] trace_in;
    logic           trace_out_valid;
    logic           trace_out_ready;
    logic [W-1:0]   trace_out_data;
    logic [1:0]     trace_out_src;
    logic [15:0]    trace_out_ts;
    logic [7:0]     drop_cnt;
    logic           overflow;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic [15:0] ts;
    } exp_t;

    // order[k] is the k-th source expected on the output (order[0] in the low bits).
    typedef struct packed {
        logic [3:0]      trig;
        logic            en;
        logic [31:0]     base;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs [7];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] tb_cyc;
    int          nvalid;
    int          prev_drop;
    logic        wrapped;

    dfd_trace_arbiter #(.N(N), .TRACEw(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .trace_en        (trace_en),
        .trigger_in      (trigger_in),
        .trace_in        (trace_in),
        .trace_out_valid (trace_out_valid),
        .trace_out_ready (trace_out_ready),
        .trace_out_data  (trace_out_data),
        .trace_out_src   (trace_out_src),
        .trace_out_ts    (trace_out_ts),
        .drop_cnt        (drop_cnt),
        .overflow        (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // Reference cycle count since reset release: the expected capture timestamp.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 16'd0;
        else        tb_cyc <= tb_cyc + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ts(input int src, input logic [31:0] data, input logic [15:0] ts);
        exp_t e;
        e.src  = src;
        e.data = data;
        e.ts   = ts;
        sb_q.push_back(e);
    endtask

    task automatic push(input int src, input logic [31:0] data);
`ifdef DFD_TRACE_TIMESTAMP_EN
        push_ts(src, data, tb_cyc);
`else
        push_ts(src, data, 16'd0);
`endif
    endtask

    task automatic set_words(input logic [31:0] base);
        for (int i = 0; i < N; i++) trace_in[i*W +: W] = base + 32'(i);
    endtask

    task automatic junk_words();
        trace_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain_wait(input string name);
        for (int k = 0; k < 30 && sb_q.size() != 0; k++) step();
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        trigger_in = '0;
        trace_en   = 1'b1;
        #2;
        chk("rst_valid", 32'(trace_out_valid), 32'd0);
        chk("rst_data", trace_out_data, 32'd0);
        chk("rst_src", 32'(trace_out_src), 32'd0);
        chk("rst_ts", 32'(trace_out_ts), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        sb_q.delete();
        trace_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    // Scoreboard: every accepted word must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset && trace_out_valid && trace_out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=src %0d data 0x%0h required=no word",
                         trace_out_src, trace_out_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", trace_out_data, e.data);
                chk("sb_src", 32'(trace_out_src), 32'(e.src));
                chk("sb_ts", 32'(trace_out_ts), 32'(e.ts));
            end
        end
    end

    initial begin
        reset           = 1'b1;
        trace_en        = 1'b1;
        trigger_in      = '0;
        trace_in        = '0;
        trace_out_ready = 1'b1;

        vecs[0] = '{trig: 4'b1111, en: 1'b1, base: 32'h1000_0000, n: 3'd4, order: 8'b11_10_01_00};
        vecs[1] = '{trig: 4'b0100, en: 1'b1, base: 32'h2000_0000, n: 3'd1, order: 8'b00_00_00_10};
        vecs[2] = '{trig: 4'b1011, en: 1'b1, base: 32'h3000_0000, n: 3'd3, order: 8'b00_01_00_11};
        vecs[3] = '{trig: 4'b0110, en: 1'b0, base: 32'h4000_0000, n: 3'd0, order: 8'b00_00_00_00};
        vecs[4] = '{trig: 4'b0001, en: 1'b1, base: 32'h5000_0000, n: 3'd1, order: 8'b00_00_00_00};
        vecs[5] = '{trig: 4'b1010, en: 1'b1, base: 32'h6000_0000, n: 3'd2, order: 8'b00_00_11_01};
        vecs[6] = '{trig: 4'b1110, en: 1'b1, base: 32'h7000_0000, n: 3'd3, order: 8'b00_11_10_01};

        do_reset();

        // Single-cycle trigger pulses, round-robin state carried from entry to entry.
        for (int v = 0; v < 7; v++) begin
            set_words(vecs[v].base);
            trigger_in = vecs[v].trig;
            trace_en   = vecs[v].en;
            for (int k = 0; k < int'(vecs[v].n); k++)
                push(int'(vecs[v].order[k]), vecs[v].base + 32'(vecs[v].order[k]));
            step();
            trigger_in = '0;
            trace_en   = 1'b1;
            junk_words();
            drain_wait($sformatf("vec%0d_drain", v));
            repeat (3) step();
            chk($sformatf("vec%0d_drop", v), 32'(drop_cnt), 32'd0);
            chk($sformatf("vec%0d_idle", v), 32'(trace_out_valid), 32'd0);
        end

        // Minimum latency: valid on the second edge after the trigger edge.
        do_reset();
        trace_in           = '0;
        trace_in[2*W +: W] = 32'hDEAD_BEEF;
        trigger_in         = 4'b0100;
        push(2, 32'hDEAD_BEEF);
        step();
        trigger_in = '0;
        junk_words();
        chk("lat_valid_e1", 32'(trace_out_valid), 32'd0);
        step();
        chk("lat_valid_e2", 32'(trace_out_valid), 32'd1);
        chk("lat_data", trace_out_data, 32'hDEAD_BEEF);
        chk("lat_src", 32'(trace_out_src), 32'd2);
        chk("lat_drop", 32'(drop_cnt), 32'd0);
        drain_wait("lat_drain");

        // Four simultaneous triggers after reset: back-to-back 0,1,2,3.
        do_reset();
        set_words(32'h3500_0000);
        trigger_in = 4'b1111;
        for (int k = 0; k < 4; k++) push(k, 32'h3500_0000 + 32'(k));
        step();
        trigger_in = '0;
        junk_words();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("b2b_valid%0d", k), 32'(trace_out_valid), 32'd1);
            chk($sformatf("b2b_src%0d", k), 32'(trace_out_src), 32'(k));
        end
        step();
        chk("b2b_end", 32'(trace_out_valid), 32'd0);
        chk("b2b_drop", 32'(drop_cnt), 32'd0);

        // Held output, second capture into the freed slot, third trigger dropped.
        do_reset();
        trace_out_ready  = 1'b0;
        trace_in[W +: W] = 32'hA1A1_0001;
        trigger_in       = 4'b0010;
        push(1, 32'hA1A1_0001);
        step();
        trigger_in = '0;
        junk_words();
        step();
        chk("hold_valid", 32'(trace_out_valid), 32'd1);
        chk("hold_data0", trace_out_data, 32'hA1A1_0001);
        trace_in[W +: W] = 32'hB2B2_0002;
        trigger_in       = 4'b0010;
        push(1, 32'hB2B2_0002);
        step();
        trigger_in = '0;
        junk_words();
        chk("hold_data1", trace_out_data, 32'hA1A1_0001);
        chk("hold_drop0", 32'(drop_cnt), 32'd0);
        step();
        trace_in[W +: W] = 32'hC3C3_0003;
        trigger_in       = 4'b0010;
        step();
        trigger_in = '0;
        chk("hold_drop1", 32'(drop_cnt), 32'd1);
        chk("hold_ovf", 32'(overflow), 32'd1);
        chk("hold_data2", trace_out_data, 32'hA1A1_0001);
        chk("hold_src", 32'(trace_out_src), 32'd1);
        // Disabled capture: pending words still drain, triggers are neither captured nor dropped.
        trace_en        = 1'b0;
        trigger_in      = 4'b0010;
        trace_out_ready = 1'b1;
        drain_wait("dis_drain");
        repeat (2) step();
        trigger_in = '0;
        trace_en   = 1'b1;
        chk("dis_drop", 32'(drop_cnt), 32'd1);
        chk("dis_idle", 32'(trace_out_valid), 32'd0);

        // Multiple drops in one cycle, then async reset while FULL.
        do_reset();
        trace_out_ready = 1'b0;
        set_words(32'h2600_0000);
        trigger_in = 4'b1111;
        step();
        chk("mdrop_e1", 32'(drop_cnt), 32'd0);
        step();
        chk("mdrop_e2", 32'(drop_cnt), 32'd3);
        step();
        chk("mdrop_e3", 32'(drop_cnt), 32'd7);
        trigger_in = '0;
        chk("mdrop_valid", 32'(trace_out_valid), 32'd1);
        chk("mdrop_src", 32'(trace_out_src), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(trace_out_valid), 32'd0);
        chk("arst_data", trace_out_data, 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset           = 1'b1;
        trace_out_ready = 1'b1;
        nvalid          = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (trace_out_valid) nvalid++;
        end
        chk("arst_stale", 32'(nvalid), 32'd0);

        // 300 drops on a blocked slot: saturate at 255, never wrap.
        do_reset();
        trace_out_ready    = 1'b0;
        trace_in[2*W +: W] = 32'h3700_0002;
        trigger_in         = 4'b0100;
        prev_drop          = 0;
        wrapped            = 1'b0;
        for (int e = 1; e <= 302; e++) begin
            step();
            if (int'(drop_cnt) < prev_drop) wrapped = 1'b1;
            prev_drop = int'(drop_cnt);
            if (e == 202) chk("sat_200", 32'(drop_cnt), 32'd200);
            if (e == 256) chk("sat_254", 32'(drop_cnt), 32'd254);
            if (e == 257) chk("sat_255", 32'(drop_cnt), 32'd255);
        end
        trigger_in = '0;
        chk("sat_final", 32'(drop_cnt), 32'd255);
        chk("sat_nowrap", 32'(wrapped), 32'd0);
        chk("sat_ovf", 32'(overflow), 32'd1);

`ifdef DFD_TRACE_TIMESTAMP_EN
        // Timestamp wrap: captures at 0xFFFE and three cycles later at 0x0001.
        do_reset();
        for (int k = 0; k < 70000 && tb_cyc != 16'hFFFE; k++) step();
        chk("ts_reach", 32'(tb_cyc), 32'h0000_FFFE);
        trace_in[0 +: W] = 32'h3900_0000;
        trigger_in       = 4'b0001;
        push_ts(0, 32'h3900_0000, 16'hFFFE);
        step();
        trigger_in = '0;
        step();
        step();
        trace_in[W +: W] = 32'h3900_0001;
        trigger_in       = 4'b0010;
        push_ts(1, 32'h3900_0001, 16'h0001);
        step();
        trigger_in = '0;
        drain_wait("ts_drain");
`endif

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dfd_trace_arbiter.md
DFD_TRACE_ARBITER -- requirements
Module: dfd_trace_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of trace sources (2..16).
REQ-002 SHALL have parameter TRACEw, default 32, trace word width.
REQ-003 SHALL have localparam Sw = log2(N), rounded up, minimum 1.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low; asserting it (low) clears all state immediately.
REQ-006 SHALL have port trace_en  in  1  capture enable; low blocks new captures.
REQ-007 SHALL have port trigger_in  in  N  per-source trigger, sampled each cycle.
REQ-008 SHALL have port trace_in  in  N*TRACEw  per-source trace word; source i occupies bits [i*TRACEw +: TRACEw].
REQ-009 SHALL have port trace_out_valid  out  1  output word valid.
REQ-010 SHALL have port trace_out_ready  in  1  downstream accept.
REQ-011 SHALL have port trace_out_data  out  TRACEw  granted trace word.
REQ-012 SHALL have port trace_out_src  out  Sw  index of the source that produced trace_out_data.
REQ-013 SHALL have port trace_out_ts  out  16  capture timestamp (see REQ-032).
REQ-014 SHALL have port drop_cnt  out  8  saturating count of lost captures.
REQ-015 SHALL have port overflow  out  1  sticky; set on the first drop.

Function
REQ-016 SHALL give each source one holding slot: pending flag, captured word and timestamp.
REQ-017 SHALL capture into slot i at an edge where trigger_in[i]=1, trace_en=1 and the slot is empty after this cycle's grant, so pending is visible 1 cycle after the trigger.
REQ-018 SHALL count a drop when a trigger hits an occupied, non-granted slot; the slot keeps its old word and the new one is discarded.
REQ-019 SHALL let a trigger arriving on a slot in the same cycle that slot is granted be captured, with no drop.
REQ-020 SHALL grant round-robin among pending slots whenever the output stage is EMPTY, or is FULL and trace_out_ready=1.
REQ-021 SHALL give priority to source (last_grant+1) mod N first, wrapping; last_grant resets to N-1, so source 0 has first priority after reset.
REQ-022 SHALL use an output FSM with states EMPTY and FULL:
- EMPTY to FULL on a grant.
- FULL stays FULL while ready=0; data, src and ts are held stable.
- FULL with ready=1 and a grant: reload, stay FULL (back-to-back, 1 word/cycle).
- FULL with ready=1 and no grant: go to EMPTY.
REQ-023 SHALL drive trace_out_valid=1 exactly when the FSM is FULL.
REQ-024 SHALL have a minimum trigger-to-valid latency of 2 cycles (capture edge, then grant/load edge).
REQ-025 SHALL give multiple simultaneous triggers on empty slots captures in the same cycle, with drop_cnt unchanged.
REQ-026 SHALL make drop_cnt saturate at 255; multiple drops in one cycle add their count, clipped at 255.
REQ-027 SHALL let trace_en=0 block captures only; already-pending slots still drain, and triggers while disabled do not count as drops.

Reset
REQ-028 SHALL, while reset is low, set FSM=EMPTY, all pending flags=0, last_grant=N-1, drop_cnt=0, overflow=0 and timestamp counter=0.
REQ-029 SHALL hold trace_out_valid=0 and trace_out_data/src/ts=0 from reset assertion.
REQ-030 SHALL discard any word held in FULL when reset asserts mid-transfer; after release it is never presented again.

Configuration
REQ-031 SHALL use the macro DFD_TRACE_TIMESTAMP_EN.
REQ-032 SHALL, when DFD_TRACE_TIMESTAMP_EN is defined:
- a 16-bit free-running counter increments every cycle and wraps 0xFFFF to 0x0000;
- the counter value at the capture edge is stored with the slot and presented on trace_out_ts.
REQ-033 SHALL, when DFD_TRACE_TIMESTAMP_EN is undefined, implement no counter and tie trace_out_ts to 0; all other behaviour is identical.

Verification
REQ-034 SHALL cover: reset low, then release; trigger_in=4'b0100 with trace_in[2]=0xDEADBEEF and ready=1 -> valid at cycle+2, data=0xDEADBEEF, src=2, drop_cnt=0.
REQ-035 SHALL cover: trigger_in=4'b1111 for one cycle with ready=1 -> four consecutive valid cycles, src order 0,1,2,3, no gaps.
REQ-036 SHALL cover: ready=0, two triggers on source 1 in cycles 5 and 7 -> first word held stable and second captured; a third trigger in cycle 9 gives drop_cnt=1, overflow=1, and the held word is unchanged.
REQ-037 SHALL cover: 300 triggers on a blocked slot -> drop_cnt=255, never wraps.
REQ-038 SHALL cover: reset asserted while FULL with ready=0 -> valid=0 at once; after release no stale word appears without a new trigger.
REQ-039 SHALL cover: with DFD_TRACE_TIMESTAMP_EN defined, a trigger at counter value 0xFFFE and a trigger 3 cycles later -> trace_out_ts values 0xFFFE then 0x0001; with the macro undefined, trace_out_ts=0.
